// File: rtl/fmul_result_stage.sv
// +----------------------------------------------------------------------------+
// | fmul_result_stage: 2-entry skid-buffered output register for the fp32 mul, |
// | with sticky flags and a delivery counter. Option macro: FMUL_CANON_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fmul_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  input  logic [3:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [3:0]        out_flags,
  input  logic              clr_sticky,
  output logic [3:0]        sticky,
  output logic [CNT_W-1:0]  result_cnt
);

  localparam logic [1:0] C_ST_EMPTY = 2'd0;
  localparam logic [1:0] C_ST_ONE   = 2'd1;
  localparam logic [1:0] C_ST_TWO   = 2'd2;

  localparam int         C_NAN_BIT  = 3;
  localparam int         C_UNF_BIT  = 1;
  localparam int         C_ZERO_BIT = 0;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [DATA_W-1:0] r_m_z;
  logic [3:0]        r_m_flags;
  logic [DATA_W-1:0] r_s_z;
  logic [3:0]        r_s_flags;
  logic [3:0]        r_sticky;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_deliver;
  logic              w_load_m_in;
  logic              w_load_m_skid;
  logic              w_load_s;

  logic [DATA_W-1:0] w_cap_z;
  logic [3:0]        w_cap_flags;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  // Capture path: optional canonicalisation of NaNs and denormals before storage.
`ifdef FMUL_CANON_EN
  localparam logic [DATA_W-1:0] C_QNAN = 32'h7FC00000;

  logic [7:0]  w_exp;
  logic [22:0] w_frac;

  assign w_exp  = in_z[30:23];
  assign w_frac = in_z[22:0];

  always_comb begin
    w_cap_z     = in_z;
    w_cap_flags = in_flags;
    if (in_flags[C_NAN_BIT] || (w_exp == 8'hFF && w_frac != 23'd0)) begin
      w_cap_z                = C_QNAN;
      w_cap_flags[C_NAN_BIT] = 1'b1;
    end else if (w_exp == 8'h00 && w_frac != 23'd0) begin
      w_cap_z                 = {in_z[DATA_W-1], {(DATA_W-1){1'b0}}};
      w_cap_flags[C_UNF_BIT]  = 1'b1;
      w_cap_flags[C_ZERO_BIT] = 1'b1;
    end
  end
`else
  assign w_cap_z     = in_z;
  assign w_cap_flags = in_flags;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_EMPTY: begin
        if (w_accept) w_state_nxt = C_ST_ONE;
      end
      C_ST_ONE: begin
        if (w_accept && !w_deliver)      w_state_nxt = C_ST_TWO;
        else if (!w_accept && w_deliver) w_state_nxt = C_ST_EMPTY;
      end
      C_ST_TWO: begin
        if (w_deliver) w_state_nxt = C_ST_ONE;
      end
      default: w_state_nxt = C_ST_EMPTY;
    endcase
  end

  // Handshake outputs decode the state register only, so no input reaches them.
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    case (r_state)
      C_ST_EMPTY: begin
        in_ready    = 1'b1;
        w_load_m_in = w_accept;
      end
      C_ST_ONE: begin
        in_ready    = 1'b1;
        out_valid   = 1'b1;
        w_load_m_in = w_accept & w_deliver;
        w_load_s    = w_accept & ~w_deliver;
      end
      C_ST_TWO: begin
        out_valid     = 1'b1;
        w_load_m_skid = w_deliver;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_z     <= '0;
      r_m_flags <= '0;
      r_s_z     <= '0;
      r_s_flags <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_z     <= w_cap_z;
        r_m_flags <= w_cap_flags;
      end else if (w_load_m_skid) begin
        r_m_z     <= r_s_z;
        r_m_flags <= r_s_flags;
      end
      if (w_load_s) begin
        r_s_z     <= w_cap_z;
        r_s_flags <= w_cap_flags;
      end
    end
  end

  // A clear and a same-cycle accept combine so that the new flags survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= '0;
    end else if (clr_sticky) begin
      r_sticky <= w_accept ? w_cap_flags : 4'b0000;
    end else if (w_accept) begin
      r_sticky <= r_sticky | w_cap_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_z      = r_m_z;
  assign out_flags  = r_m_flags;
  assign sticky     = r_sticky;
  assign result_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fmul_result_stage.sv
// +----------------------------------------------------------------------------+
// | tb_fmul_result_stage: directed self-checking bench for fmul_result_stage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fmul_result_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
`ifdef FMUL_CANON_EN
  localparam bit CANON = 1'b1;
`else
  localparam bit CANON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_z;
  logic [3:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_z;
  logic [3:0]        out_flags;
  logic              clr_sticky;
  logic [3:0]        sticky;
  logic [CNT_W-1:0]  result_cnt;

  int n_vec = 0;
  int n_err = 0;

  fmul_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_z       (in_z),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_flags  (out_flags),
    .clr_sticky (clr_sticky),
    .sticky     (sticky),
    .result_cnt (result_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] z, input logic [3:0] f);
    in_valid = 1'b1;
    in_z     = z;
    in_flags = f;
  endtask

  initial begin
    // 1. reset held with in_valid asserted
    rst = 1'b1; clr_sticky = 1'b0; out_ready = 1'b0;
    push(32'hDEADBEEF, 4'hF);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sticky", sticky, 0);
    chk("rst_cnt", result_cnt, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_flags", out_flags, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_out_valid", out_valid, 0);

    // 2. streaming with out_ready high
    out_ready = 1'b1;
    push(32'h3F800000, 4'h0); tick();
    chk("s_w0", out_z, 32'h3F800000);
    chk("s_v0", out_valid, 1);
    push(32'h40000000, 4'h0); tick();
    chk("s_w1", out_z, 32'h40000000);
    chk("s_c1", result_cnt, 1);
    push(32'h40400000, 4'h0); tick();
    chk("s_w2", out_z, 32'h40400000);
    chk("s_c2", result_cnt, 2);
    in_valid = 1'b0; in_z = 'x; in_flags = 'x; tick();
    chk("s_drain_valid", out_valid, 0);
    chk("s_cnt3", result_cnt, 3);
    tick();
    chk("x_ignored_z", out_z, 32'h40400000);
    chk("x_ignored_sticky", sticky, 0);

    // 3. backpressure: third word must wait upstream
    out_ready = 1'b0;
    push(32'h11111111, 4'h0); tick();
    chk("bp_rdy1", in_ready, 1);
    chk("bp_z_a", out_z, 32'h11111111);
    push(32'h22222222, 4'h0); tick();
    chk("bp_rdy2", in_ready, 0);
    push(32'h33333333, 4'h0); tick();
    chk("bp_hold_z", out_z, 32'h11111111);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_rdy", in_ready, 0);
    out_ready = 1'b1; tick();
    chk("bp_z_b", out_z, 32'h22222222);
    chk("bp_rdy3", in_ready, 1);
    chk("bp_cnt4", result_cnt, 4);
    tick();
    chk("bp_z_c", out_z, 32'h33333333);
    chk("bp_cnt5", result_cnt, 5);
    in_valid = 1'b0; tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_cnt6", result_cnt, 6);

    // 4. sticky accumulation and clear with simultaneous accept
    push(32'h3F800000, 4'b1000); tick();
    chk("st_1000", sticky, 4'b1000);
    chk("st_flags_m", out_flags, 4'b1000);
    push(32'h3F800000, 4'b0001); tick();
    chk("st_1001", sticky, 4'b1001);
    clr_sticky = 1'b1;
    push(32'h3F800000, 4'b0100); tick();
    chk("st_clr_acc", sticky, 4'b0100);
    clr_sticky = 1'b0; in_valid = 1'b0; tick();
    chk("st_cnt9", result_cnt, 9);

    // 5. canonicalisation (or bit-exact passthrough)
    push(32'hFF812345, 4'b0000); tick();
    chk("cn_nan_z", out_z, CANON ? 32'h7FC00000 : 32'hFF812345);
    chk("cn_nan_f", out_flags, CANON ? 4'b1000 : 4'b0000);
    push(32'h80000001, 4'b0000); tick();
    chk("cn_den_z", out_z, CANON ? 32'h80000000 : 32'h80000001);
    chk("cn_den_f", out_flags, CANON ? 4'b0011 : 4'b0000);
    in_valid = 1'b0; tick();
    chk("cn_sticky", sticky, CANON ? 4'b1111 : 4'b0100);
    chk("cn_cnt11", result_cnt, 11);

    // 6. reset while full, then counter wrap with CNT_W=4
    out_ready = 1'b0;
    push(32'hAAAA0001, 4'h0); tick();
    push(32'hAAAA0002, 4'h0); tick();
    chk("r2_full", in_ready, 0);
    rst = 1'b1; push(32'hBBBBBBBB, 4'hF); tick();
    chk("r2_valid", out_valid, 0);
    chk("r2_rdy", in_ready, 1);
    chk("r2_cnt", result_cnt, 0);
    chk("r2_sticky", sticky, 0);
    rst = 1'b0; out_ready = 1'b1;
    push(32'h12345678, 4'h0); tick();
    chk("r2_new_z", out_z, 32'h12345678);
    chk("r2_new_v", out_valid, 1);
    for (int i = 0; i < 16; i++) begin
      push(32'hA0000000 + 32'(i), 4'h0); tick();
      chk("wrap_z", out_z, 32'hA0000000 + 32'(i));
    end
    in_valid = 1'b0; tick();
    chk("wrap_empty", out_valid, 0);
    chk("wrap_cnt", result_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
